// File: rtl/led_ctrl_multi.sv
// led_ctrl_multi: multi-channel LED controller with shared prescaler and per-channel OFF/ON/BLINK/PWM modes
module led_ctrl_multi #(
    parameter int NUM_CH     = 4,
    parameter int PRESCALE   = 50000,
    parameter int PERIOD_W   = 8,
    parameter int DEF_PERIOD = 255
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       sync,
    input  logic                                       wr_en,
    input  logic [(NUM_CH > 1 ? $clog2(NUM_CH) : 1)-1:0] wr_ch,
    input  logic [1:0]                                 wr_mode,
    input  logic [PERIOD_W-1:0]                        wr_period,
    input  logic [PERIOD_W-1:0]                        wr_duty,
    output logic                                       tick,
    output logic [NUM_CH-1:0]                          led
);
    localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;

    typedef enum logic [1:0] {M_OFF, M_ON, M_BLINK, M_PWM} mode_t;

    logic [PW-1:0] pcnt;
    logic          pwrap;

    assign pwrap = pcnt == PW'(PRESCALE - 1);
    // sync restarts the prescaler, so its tick is swallowed that cycle
    assign tick  = ~rst & ~sync & pwrap;

    // prescaler: 0..PRESCALE-1, restarted by reset or sync
    always_ff @(posedge clk) begin
        pcnt <= (rst || sync || pwrap) ? '0 : pcnt + 1'b1;
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        mode_t               mode;
        logic [PERIOD_W-1:0] period;
        logic [PERIOD_W-1:0] duty;
        logic [PERIOD_W-1:0] cnt;
        logic                led_q;
        logic                led_nxt;
        logic                sel;
        logic                wrap;

        assign sel    = wr_en && (32'(wr_ch) == i);
        assign wrap   = cnt == period;
        assign led[i] = led_q;

        // steady-state LED value for the current mode
        always_comb begin
            led_nxt = mode == M_ON    ? 1'b1 :
                      mode == M_BLINK ? ((tick && wrap) ? ~led_q : led_q) :
                      mode == M_PWM   ? (cnt < duty) : 1'b0;
        end

        // channel config and counter; a write to this channel beats sync and tick
        always_ff @(posedge clk) begin
            if (rst) begin
                mode   <= M_OFF;
                period <= PERIOD_W'(DEF_PERIOD);
                duty   <= '0;
                cnt    <= '0;
                led_q  <= 1'b0;
            end else if (sel) begin
                mode   <= mode_t'(wr_mode);
                period <= wr_period;
                duty   <= wr_duty;
                cnt    <= '0;
                led_q  <= 1'b0;
            end else begin
                cnt    <= sync ? '0 : tick ? (wrap ? '0 : cnt + 1'b1) : cnt;
                led_q  <= (sync && mode == M_BLINK) ? 1'b0 : led_nxt;
            end
        end
    end
endmodule
